// File: rtl/alu_issuer.sv
// Sequencer that latches a host request, drives a bit-serial ALU for a fixed
// number of beats, captures its result and holds it until the host consumes it.
module alu_issuer #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    input  logic [2:0]       req_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic [2:0]       alu_opcode,
    input  logic [3:0]       alu_c,
    input  logic             alu_carr,
    input  logic             alu_sign,
    input  logic             alu_zero,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [3:0]       res_c,
    output logic             res_carr,
    output logic             res_sign,
    output logic             res_zero,
    output logic             res_err,
    output logic [CNT_W-1:0] op_count
);

    localparam int unsigned DW  = 4;
    localparam int unsigned OPW = 3;
    localparam int unsigned BW  = 2;
    localparam logic [OPW-1:0] OP_PARK  = OPW'(0);
    localparam logic [OPW-1:0] OP_LAST  = OPW'(4);
    localparam logic [BW-1:0]  BEAT_END = BW'(3);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        CAPTURE,
        DONE
    } state_t;

    state_t           state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [OPW-1:0]   op_q, op_d;
    logic [DW-1:0]    alu_a_d, alu_b_d, res_c_d;
    logic [OPW-1:0]   alu_opcode_d;
    logic             res_carr_d, res_sign_d, res_zero_d, res_err_d;
    logic             req_ready_d, res_valid_d;
    logic [CNT_W-1:0] op_count_d;

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_q     <= '0;
            op_q       <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_opcode <= '0;
            res_c      <= '0;
            res_carr   <= 1'b0;
            res_sign   <= 1'b0;
            res_zero   <= 1'b0;
            res_err    <= 1'b0;
            req_ready  <= 1'b1;
            res_valid  <= 1'b0;
            op_count   <= '0;
        end else begin
            state_q    <= state_d;
            beat_q     <= beat_d;
            op_q       <= op_d;
            alu_a      <= alu_a_d;
            alu_b      <= alu_b_d;
            alu_opcode <= alu_opcode_d;
            res_c      <= res_c_d;
            res_carr   <= res_carr_d;
            res_sign   <= res_sign_d;
            res_zero   <= res_zero_d;
            res_err    <= res_err_d;
            req_ready  <= req_ready_d;
            res_valid  <= res_valid_d;
            op_count   <= op_count_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d      = state_q;
        beat_d       = beat_q;
        op_d         = op_q;
        alu_a_d      = alu_a;
        alu_b_d      = alu_b;
        alu_opcode_d = alu_opcode;
        res_c_d      = res_c;
        res_carr_d   = res_carr;
        res_sign_d   = res_sign;
        res_zero_d   = res_zero;
        res_err_d    = res_err;
        op_count_d   = op_count;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_op <= OP_LAST) begin
                        state_d      = ISSUE;
                        beat_d       = '0;
                        op_d         = req_op;
                        alu_a_d      = req_a;
                        alu_b_d      = req_b;
                        alu_opcode_d = req_op;
                    end else begin
                        // Illegal opcode: report an error without touching the ALU
                        state_d    = DONE;
                        res_c_d    = '0;
                        res_carr_d = 1'b0;
                        res_sign_d = 1'b0;
                        res_zero_d = 1'b0;
                        res_err_d  = 1'b1;
                    end
                end
            end
            ISSUE: begin
                if (op_q == OP_PARK || beat_q == BEAT_END) begin
                    state_d      = CAPTURE;
                    alu_opcode_d = OP_PARK;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            CAPTURE: begin
                state_d    = DONE;
                res_c_d    = alu_c;
                res_carr_d = alu_carr;
                res_sign_d = alu_sign;
                res_zero_d = alu_zero;
                res_err_d  = 1'b0;
            end
            DONE: begin
                if (res_ready) begin
                    state_d    = IDLE;
                    op_count_d = op_count + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        req_ready_d = (state_d == IDLE);
        res_valid_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_alu_issuer.sv
// Directed bench for alu_issuer: a timing-level reference model checked every
// cycle, plus literal expectations for latency, ALU activity and results.
module tb_alu_issuer;

    logic       clk;
    logic       rst_n;
    logic       req_valid;
    logic       req_ready;
    logic [3:0] req_a, req_b;
    logic [2:0] req_op;
    logic [3:0] alu_a, alu_b;
    logic [2:0] alu_opcode;
    logic [3:0] alu_c;
    logic       alu_carr, alu_sign, alu_zero;
    logic       res_valid;
    logic       res_ready;
    logic [3:0] res_c;
    logic       res_carr, res_sign, res_zero, res_err;
    logic [7:0] op_count;

    int checks = 0;
    int errors = 0;
    int nz_cnt = 0;

    // Stub ALU: returns the programmed result only while parked, garbage otherwise
    logic [3:0] stub_c;
    logic       stub_carr, stub_sign, stub_zero;
    assign alu_c    = (alu_opcode != 3'd0) ? ~stub_c    : stub_c;
    assign alu_carr = (alu_opcode != 3'd0) ? ~stub_carr : stub_carr;
    assign alu_sign = (alu_opcode != 3'd0) ? ~stub_sign : stub_sign;
    assign alu_zero = (alu_opcode != 3'd0) ? ~stub_zero : stub_zero;

    alu_issuer #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_op     (req_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_opcode (alu_opcode),
        .alu_c      (alu_c),
        .alu_carr   (alu_carr),
        .alu_sign   (alu_sign),
        .alu_zero   (alu_zero),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_c      (res_c),
        .res_carr   (res_carr),
        .res_sign   (res_sign),
        .res_zero   (res_zero),
        .res_err    (res_err),
        .op_count   (op_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Edges from accept (inclusive) until the result is visible
    function automatic int lat_of(input logic [2:0] op);
        if (op > 3'd4) return 1;
        if (op == 3'd0) return 3;
        return 6;
    endfunction

    // Reference model: tracks edges since acceptance, not DUT states
    logic       m_busy, m_done;
    int         m_k, m_lat;
    logic [2:0] m_op;
    logic [3:0] m_a, m_b, m_c;
    logic       m_carr, m_sign, m_zero, m_err;
    logic [7:0] m_count;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_k <= 0; m_lat <= 0; m_op <= 3'd0;
            m_a <= 4'd0; m_b <= 4'd0; m_c <= 4'd0;
            m_carr <= 1'b0; m_sign <= 1'b0; m_zero <= 1'b0; m_err <= 1'b0;
            m_count <= 8'd0;
        end else if (!m_busy) begin
            if (req_valid) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_op   <= req_op;
                m_lat  <= lat_of(req_op);
                if (req_op <= 3'd4) begin
                    m_a <= req_a;
                    m_b <= req_b;
                end else begin
                    m_done <= 1'b1;
                    m_c <= 4'd0; m_carr <= 1'b0; m_sign <= 1'b0; m_zero <= 1'b0;
                    m_err <= 1'b1;
                end
            end
        end else if (m_done) begin
            if (res_ready) begin
                m_busy  <= 1'b0;
                m_done  <= 1'b0;
                m_count <= m_count + 8'd1;
            end
        end else begin
            m_k <= m_k + 1;
            if (m_k + 1 == m_lat - 1) begin
                m_done <= 1'b1;
                m_c <= stub_c; m_carr <= stub_carr; m_sign <= stub_sign; m_zero <= stub_zero;
                m_err <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst_n) begin
            logic [2:0] exp_opc;
            exp_opc = (m_busy && !m_done && m_op >= 3'd1 && m_op <= 3'd4 && m_k <= 3) ? m_op : 3'd0;
            if (alu_opcode != 3'd0) nz_cnt++;
            chk("req_ready", int'(req_ready), int'(!m_busy));
            chk("res_valid", int'(res_valid), int'(m_done));
            chk("alu_opcode", int'(alu_opcode), int'(exp_opc));
            chk("alu_a", int'(alu_a), int'(m_a));
            chk("alu_b", int'(alu_b), int'(m_b));
            chk("op_count", int'(op_count), int'(m_count));
            if (m_done) begin
                chk("res_c", int'(res_c), int'(m_c));
                chk("res_carr", int'(res_carr), int'(m_carr));
                chk("res_sign", int'(res_sign), int'(m_sign));
                chk("res_zero", int'(res_zero), int'(m_zero));
                chk("res_err", int'(res_err), int'(m_err));
            end
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic [3:0] sc, input logic sca, input logic ssg, input logic szr,
                          input int hold, input int exp_lat, input int exp_nz,
                          input logic [3:0] exp_c, input logic exp_err);
        int lat, nz0, w;
        logic [3:0] c0;
        logic e0;
        stub_c = sc; stub_carr = sca; stub_sign = ssg; stub_zero = szr;
        @(negedge clk);
        w = 0;
        while (!req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        nz0 = nz_cnt;
        req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
        @(posedge clk);
        lat = 1;
        @(negedge clk);
        req_valid = 1'b0; req_a = ~a; req_b = ~b; req_op = 3'd5;
        while (!res_valid && lat < 20) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", lat, exp_lat);
        if (!res_valid) return;
        chk("lit_res_c", int'(res_c), int'(exp_c));
        chk("lit_res_err", int'(res_err), int'(exp_err));
        c0 = res_c; e0 = res_err;
        for (int i = 0; i < hold; i++) begin
            req_valid = (i % 2 == 0);
            @(negedge clk);
            chk("hold_res_c", int'(res_c), int'(c0));
            chk("hold_res_err", int'(res_err), int'(e0));
            chk("hold_req_ready", int'(req_ready), 0);
            chk("hold_res_valid", int'(res_valid), 1);
        end
        req_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        res_ready = 1'b0;
        chk("idle_after_hs", int'(req_ready), 1);
        chk("alu_active_cycles", nz_cnt - nz0, exp_nz);
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; res_ready = 1'b0;
        req_a = 4'd0; req_b = 4'd0; req_op = 3'd0;
        stub_c = 4'd0; stub_carr = 1'b0; stub_sign = 1'b0; stub_zero = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_alu_opcode", int'(alu_opcode), 0);
        chk("rst_alu_a", int'(alu_a), 0);
        chk("rst_res_valid", int'(res_valid), 0);
        chk("rst_op_count", int'(op_count), 0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_req_ready", int'(req_ready), 1);

        // ADD 3+5 with backpressure and ignored request pulses
        run_op(3'd4, 4'd3, 4'd5, 4'b1000, 1'b0, 1'b1, 1'b0, 10, 6, 4, 4'b1000, 1'b0);
        chk("add_res_sign", int'(res_sign), 1);
        chk("add_op_count", int'(op_count), 1);
        // Illegal opcode 110
        run_op(3'd6, 4'd7, 4'd2, 4'b0101, 1'b1, 1'b1, 1'b1, 0, 1, 0, 4'd0, 1'b1);
        chk("err_op_count", int'(op_count), 2);
        // Reset opcode 000
        run_op(3'd0, 4'd1, 4'd1, 4'b0000, 1'b0, 1'b0, 1'b1, 1, 3, 0, 4'd0, 1'b0);
        run_op(3'd1, 4'hA, 4'h5, 4'b0000, 1'b0, 1'b0, 1'b1, 0, 6, 4, 4'd0, 1'b0);
        run_op(3'd3, 4'hF, 4'hF, 4'b0000, 1'b0, 1'b0, 1'b1, 2, 6, 4, 4'd0, 1'b0);
        run_op(3'd2, 4'd2, 4'd3, 4'hF, 1'b1, 1'b1, 1'b0, 3, 6, 4, 4'hF, 1'b0);
        run_op(3'd7, 4'd9, 4'd9, 4'h3, 1'b0, 1'b0, 1'b0, 0, 1, 0, 4'd0, 1'b1);
        chk("seq_op_count", int'(op_count), 7);

        // Asynchronous reset at beat 2 of a SUB
        stub_c = 4'h6; stub_carr = 1'b0; stub_sign = 1'b0; stub_zero = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd2; req_a = 4'd9; req_b = 4'd4;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("abort_pre_opcode", int'(alu_opcode), 2);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_alu_opcode", int'(alu_opcode), 0);
        chk("abort_alu_a", int'(alu_a), 0);
        chk("abort_alu_b", int'(alu_b), 0);
        chk("abort_res_valid", int'(res_valid), 0);
        chk("abort_res_c", int'(res_c), 0);
        chk("abort_res_err", int'(res_err), 0);
        chk("abort_op_count", int'(op_count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("abort_req_ready", int'(req_ready), 1);
        run_op(3'd2, 4'd9, 4'd4, 4'h5, 1'b0, 1'b0, 1'b0, 0, 6, 4, 4'h5, 1'b0);
        chk("post_abort_count", int'(op_count), 1);

        // 256 back-to-back operations from a fresh reset: counter wraps
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 256; i++) begin
            logic [2:0] op;
            logic [3:0] v;
            op = 3'(i % 8);
            v  = 4'(i);
            run_op(op, v, ~v, v, v[0], v[1], v[2], 0, lat_of(op),
                   (op >= 3'd1 && op <= 3'd4) ? 4 : 0,
                   (op > 3'd4) ? 4'd0 : v, (op > 3'd4));
            if (i == 254) chk("wrap_pre", int'(op_count), 255);
            if (i == 255) chk("wrap_zero", int'(op_count), 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
